stack_pop_streamer: RTL

//  Pop-side stage placed directly downstream of the register stack. It drains the stack's zero-latency
//  top-of-stack port into a 2-entry registered output buffer and presents the popped items on a

---
 rtl/stack_pop_streamer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/stack_pop_streamer.sv
// ---------------------------------------------------------------------------
// stack_pop_streamer
//
// Pop-side stage that sits directly downstream of a register stack. The
// stack's top-of-stack port has zero latency, so this block decides each
// cycle whether to pop. Each popped item goes into a 2-entry registered
// buffer, and the block presents the items on a valid/ready stream.
// - It sustains one item per cycle while m_ready stays high.
// - No stream output (m_valid, m_data) is combinationally driven from the
//   stack.
//
// Optional feature:
//   STACK_POP_CNT_EN  When defined, the block adds the o_pop_cnt port and a
//                     counter of popped items. The counter wraps modulo
//                     2^CNT_W and i_flush does not clear it.
//
// Parameters:
//   DATA_W  item width; must match the stack's item width.
//   CNT_W   popped-item counter width (only used with STACK_POP_CNT_EN).
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   i_flush    one-cycle pulse that discards buffered items
//   s_empty    stack empty flag
//   s_data     stack top-of-stack data, valid in the same cycle
//   s_pop      pop request to the stack (combinational)
//   m_valid    output item valid (registered)
//   m_data     output item (registered)
//   m_ready    downstream accepts when m_valid && m_ready
//   o_pop_cnt  items popped since reset (STACK_POP_CNT_EN only)
// ---------------------------------------------------------------------------
module stack_pop_streamer #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              s_empty,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_pop,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
`ifdef STACK_POP_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_pop_cnt
`endif
);

  // Reject degenerate configurations at elaboration time.
  if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("stack_pop_streamer: DATA_W and CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e              cnt_q, cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              take;

  // The pop is gated by rst so that the stack is not drained while the
  // buffer is held in reset. No pop happens in TWO, so the buffer can never
  // overflow.
  assign s_pop   = !rst && !s_empty && (cnt_q != TWO) && !i_flush;
  assign m_valid = (cnt_q != EMPTY);
  assign m_data  = head_q;
  assign take    = m_valid && m_ready;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    skid_d = skid_q;
    unique case (cnt_q)
      EMPTY: begin
        if (s_pop) begin
          head_d = s_data;
          cnt_d  = ONE;
        end
      end
      ONE: begin
        if (s_pop && take) begin
          // The head leaves and the new item replaces it.
          // Occupancy stays at ONE, which gives full-rate streaming.
          head_d = s_data;
        end else if (s_pop) begin
          skid_d = s_data;
          cnt_d  = TWO;
        end else if (take) begin
          cnt_d  = EMPTY;
        end
      end
      TWO: begin
        if (take) begin
          head_d = skid_q;
          cnt_d  = ONE;
        end
      end
      default: cnt_d = EMPTY;
    endcase
    // A take in the same cycle has already left. The flush discards
    // whatever remains; the data registers keep stale values, which is
    // harmless.
    if (i_flush) begin
      cnt_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

`ifdef STACK_POP_CNT_EN
  logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;

  always_comb begin
    pop_cnt_d = pop_cnt_q;
    if (s_pop) begin
      pop_cnt_d = pop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_cnt_q <= '0;
    end else begin
      pop_cnt_q <= pop_cnt_d;
    end
  end

  assign o_pop_cnt = pop_cnt_q;
`endif

endmodule
